// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared definitions for the pipelined adder.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   chunk_of()             : bits handled per pipeline segment
//   sat_max() / sat_min()  : signed saturation limits for a given width,
//                            used when PIPE_ADDER_SAT_EN is defined
package pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned MAX_WIDTH  = 64;

  localparam logic [MAX_WIDTH-1:0] ONE = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

  function automatic int unsigned chunk_of(input int unsigned width,
                                           input int unsigned stages);
    return width / stages;
  endfunction

  // 0x7F..F in the low `width` bits
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned width);
    return (ONE << (width - 1)) - ONE;
  endfunction

  // 0x80..0 in the low `width` bits
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned width);
    return ONE << (width - 1);
  endfunction

endpackage

// File: rtl/pipe_adder_chunk.sv
// adder_chunk: CHUNK-bit ripple-carry adder built from full-adder cells.
//   a, b   : CHUNK-bit operands
//   ci     : carry in
//   sum    : CHUNK-bit sum
//   co     : carry out of the top bit
//   c_msb  : carry into the top bit (for signed overflow detection)
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CHUNK = chunk_of(DEF_WIDTH, DEF_STAGES)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract split into STAGES registered
// carry-chain segments with valid/ready handshakes on both sides.
//   clk, reset_n         : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub)
//   sub                  : 0 = a+b, 1 = a-b
//   out_valid / out_ready: result handshake (sum, co, ovf)
//   co                   : carry out of MSB (for sub: 1 = no borrow)
//   ovf                  : two's-complement signed overflow
// Optional macro PIPE_ADDER_SAT_EN: saturate sum to the signed limits
// whenever ovf=1 (ovf and co unchanged).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [MAX_WIDTH-1:0] SAT_MAX_FULL = sat_max(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SAT_MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
`endif

  // A held result freezes every stage, so bubbles are never squeezed out.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_v;
    logic             src_c;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic [CHUNK-1:0] ch_s;
    logic             ch_c;
    logic             ch_m;
    logic [WIDTH-1:0] nxt_s;

    // Stage 0 folds subtraction into inverted B plus carry-in; later
    // stages take the beat from the previous stage register.
    if (k == 0) begin : g_src
      assign src_v = in_valid;
      assign src_a = a;
      assign src_b = sub ? ~b : b;
      assign src_s = '0;
      assign src_c = sub;
    end else begin : g_src
      assign src_v = g_stage[k-1].g_fwd.q_v;
      assign src_a = g_stage[k-1].g_fwd.q_a;
      assign src_b = g_stage[k-1].g_fwd.q_b;
      assign src_s = g_stage[k-1].g_fwd.q_s;
      assign src_c = g_stage[k-1].g_fwd.q_c;
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (src_a[k*CHUNK +: CHUNK]),
      .b     (src_b[k*CHUNK +: CHUNK]),
      .ci    (src_c),
      .sum   (ch_s),
      .co    (ch_c),
      .c_msb (ch_m)
    );

    always_comb begin
      nxt_s                   = src_s;
      nxt_s[k*CHUNK +: CHUNK] = ch_s;
    end

    if (k < STAGES - 1) begin : g_fwd
      logic             q_v;
      logic             q_c;
      logic [WIDTH-1:0] q_a;
      logic [WIDTH-1:0] q_b;
      logic [WIDTH-1:0] q_s;
      logic             unused_cm;

      // Carry into the chunk MSB only matters at the true MSB.
      assign unused_cm = ch_m;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_v <= 1'b0;
          q_c <= 1'b0;
          q_a <= '0;
          q_b <= '0;
          q_s <= '0;
        end else if (!stall) begin
          q_v <= src_v;
          q_c <= ch_c;
          q_a <= src_a;
          q_b <= src_b;
          q_s <= nxt_s;
        end
      end
    end else begin : g_last
      logic             q_v;
      logic             q_c;
      logic             q_ovf;
      logic [WIDTH-1:0] q_s;
      logic             ovf_d;
      logic [WIDTH-1:0] res_s;
      logic             unused_ops;

      assign ovf_d      = ch_c ^ ch_m;
      assign unused_ops = ^{src_a, src_b};

`ifdef PIPE_ADDER_SAT_EN
      // On overflow both effective operands share A's sign, which
      // therefore gives the overflow direction.
      assign res_s = ovf_d ? (src_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : nxt_s;
`else
      assign res_s = nxt_s;
`endif

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_v   <= 1'b0;
          q_c   <= 1'b0;
          q_ovf <= 1'b0;
          q_s   <= '0;
        end else if (!stall) begin
          q_v   <= src_v;
          q_c   <= ch_c;
          q_ovf <= ovf_d;
          q_s   <= res_s;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].g_last.q_v;
  assign sum       = g_stage[STAGES-1].g_last.q_s;
  assign co        = g_stage[STAGES-1].g_last.q_c;
  assign ovf       = g_stage[STAGES-1].g_last.q_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: self-checking bench for pipe_adder (16-bit/4-stage and
// 8-bit/1-stage instances). Honours PIPE_ADDER_SAT_EN when defined.
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, co, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, co8, ovf8;
  logic [7:0]  a8, b8, sum8;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .co(co8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;

  // Directed vectors with hand-computed results
  logic [15:0] va [8] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005,
                          16'h8000, 16'h1234, 16'h0003, 16'h8000};
  logic [15:0] vb [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007,
                          16'h0001, 16'h4321, 16'h0003, 16'h8000};
  logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef PIPE_ADDER_SAT_EN
  logic [15:0] es [8] = '{16'h0100, 16'h0000, 16'h7FFF, 16'hFFFE,
                          16'h8000, 16'h5555, 16'h0000, 16'h8000};
`else
  logic [15:0] es [8] = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE,
                          16'h7FFF, 16'h5555, 16'h0000, 16'h0000};
`endif
  logic        ec [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        eo [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // Reference: signed/unsigned integer arithmetic on the operands.
  function automatic res_t model16(input logic [15:0] x, input logic [15:0] y,
                                   input logic s);
    res_t        r;
    int          sx, sy, full;
    int unsigned ux, uy;
    logic [31:0] w;
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    ux   = 32'(x);
    uy   = 32'(y);
    full = s ? sx - sy : sx + sy;
    w    = full;
    r.s  = w[15:0];
    r.c  = s ? (ux >= uy) : ((ux + uy) > 32'd65535);
    r.o  = (full > 32767) || (full < -32768);
`ifdef PIPE_ADDER_SAT_EN
    if (r.o) r.s = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: record accepted beats, check every presented result.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready) exp_q.push_back(model16(a, b, sub));
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream: unexpected result sum=0x%h with nothing outstanding", sum);
        end else begin
          if ({sum, co, ovf} !== {exp_q[0].s, exp_q[0].c, exp_q[0].o}) begin
            errors++;
            $display("FAIL stream: got sum=0x%h co=%b ovf=%b, expected sum=0x%h co=%b ovf=%b",
                     sum, co, ovf, exp_q[0].s, exp_q[0].c, exp_q[0].o);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s);
    bit ok;
    int n;
    n = 0;
    a = x; b = y; sub = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send: in_ready stayed low for 100 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  // Called just after a rising edge with an empty pipeline.
  task automatic lat_test(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input logic [15:0] xs, input logic xc, input logic xo);
    a = x; b = y; sub = s; in_valid = 1'b1;
    chk("lat_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("lat_early_valid_c%0d", i), out_valid, 0);
      @(posedge clk);
      #1;
    end
    chk("lat_out_valid", out_valid, 1);
    chk("lat_sum", sum, xs);
    chk("lat_co", co, xc);
    chk("lat_ovf", ovf, xo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   d0;
    res_t r;
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sum", sum, 0);
    chk("reset_co", co, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_out_valid8", out_valid8, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      r = model16(va[i], vb[i], vs[i]);
      chk($sformatf("model_sum_%0d", i), r.s, es[i]);
      chk($sformatf("model_co_%0d", i), r.c, ec[i]);
      chk($sformatf("model_ovf_%0d", i), r.o, eo[i]);
    end

    lat_test(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    drain();

    // 8 back-to-back beats, out_ready low on cycles 6-8
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++) send(va[i], vb[i], vs[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_delivered", delivered - d0, 8);

    // Bubbles and random back-pressure
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(va[7-i], vb[7-i], ~vs[7-i]);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bubble_delivered", delivered - d0, 8);

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) send(va[i], vb[i], vs[i]);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", out_valid, 1);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_valid_now", out_valid, 0);
    chk("rst_sum_now", sum, 0);
    chk("rst_in_ready_now", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_reset_out_valid", out_valid, 0);
    end
    lat_test(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    drain();

    // STAGES=1, WIDTH=8
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; in_valid8 = 1'b1;
    chk("s1_in_ready", in_ready8, 1);
    chk("s1_idle_valid", out_valid8, 0);
    @(posedge clk);
    #1;
    a8 = 8'h7F; b8 = 8'h01;
    chk("s1_valid", out_valid8, 1);
`ifdef PIPE_ADDER_SAT_EN
    chk("s1_sum", sum8, 8'h80);
`else
    chk("s1_sum", sum8, 8'h00);
`endif
    chk("s1_co", co8, 1);
    chk("s1_ovf", ovf8, 1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    chk("s1b_valid", out_valid8, 1);
`ifdef PIPE_ADDER_SAT_EN
    chk("s1b_sum", sum8, 8'h7F);
`else
    chk("s1b_sum", sum8, 8'h80);
`endif
    chk("s1b_co", co8, 0);
    chk("s1b_ovf", ovf8, 1);
    @(posedge clk);
    #1;
    chk("s1_drained", out_valid8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
